psum_xchg_sched: RTL and testbench

- Controller that sequences the cross-core partial-sum exchange between the two cores of the two-core top level.
- Per output row it:
  - commands both cores to emit their local sum;
  - waits until both inter-core FIFOs hold an entry;
  - pops both FIFOs in the same cycle;
  - tells each core to latch the remote sum;
  - holds the normalize enable for a fixed window.
- Counts rows, reports done, and flags FIFO overflow. Sits at top level beside the two FIFOs and drives their read enables.

---
 rtl/xchg_pkg.sv | 19 +
 rtl/xchg_err_mon.sv | 78 +++++++
 rtl/psum_xchg_sched.sv | 164 ++++++++++++++++
 tb/tb_psum_xchg_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xchg_pkg.sv
// Shared types and default constants for the partial-sum exchange scheduler.
// Holds the FSM state encoding used by the top and the error monitor.
package xchg_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        POP  = 3'd3,
        LD   = 3'd4,
        NORM = 3'd5,
        DONE = 3'd6
    } state_e;

    localparam int NROW_W_DEF   = 5;
    localparam int NORM_CYC_DEF = 2;
    localparam int TO_CYC_DEF   = 255;

endpackage

// File: rtl/xchg_err_mon.sv
// Overflow detection, WAIT timeout counter and the sticky error flags.
// Timeout logic exists only when XCHG_TIMEOUT_EN is defined.
module xchg_err_mon
    import xchg_pkg::*;
#(
    parameter int TO_CYC = TO_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic wait_entry_i,
    input  logic in_wait_i,
    input  logic both_rdy_i,
    input  logic sum_out_vld0_i,
    input  logic full0_i,
    input  logic sum_out_vld1_i,
    input  logic full1_i,
    output logic err_ovf_o,
    output logic err_to_o,
    output logic to_hit_o
);

    logic ovf;
    logic err_ovf_q;

    assign ovf       = (sum_out_vld0_i & full0_i) | (sum_out_vld1_i & full1_i);
    assign err_ovf_o = err_ovf_q;

    // Sticky overflow: a new run clears it, a write into a full FIFO sets it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_ovf_q <= 1'b0;
        end else begin
            err_ovf_q <= (clr_i ? 1'b0 : err_ovf_q) | ovf;
        end
    end

`ifdef XCHG_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYC + 1);

    logic [CW-1:0] to_cnt_q;
    logic          err_to_q;

    // The cycle that would bring the count to TO_CYC is the expiring one.
    assign to_hit_o = in_wait_i & ~both_rdy_i
                    & (to_cnt_q == CW'(TO_CYC - 1));
    assign err_to_o = err_to_q;

    // Count WAIT cycles, restarting every time WAIT is entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else if (wait_entry_i) begin
            to_cnt_q <= '0;
        end else if (in_wait_i) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    // Sticky timeout flag with the same clear rule as overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_to_q <= 1'b0;
        end else if (clr_i) begin
            err_to_q <= 1'b0;
        end else if (to_hit_o) begin
            err_to_q <= 1'b1;
        end
    end
`else
    logic unused_to;

    assign unused_to = wait_entry_i ^ in_wait_i ^ both_rdy_i;
    assign to_hit_o  = 1'b0;
    assign err_to_o  = 1'b0;
`endif

endmodule

// File: rtl/psum_xchg_sched.sv
// Sequences the per-row partial-sum exchange between the two cores.
// Optional WAIT timeout is enabled with the XCHG_TIMEOUT_EN macro.
module psum_xchg_sched
    import xchg_pkg::*;
#(
    parameter int NROW_W   = NROW_W_DEF,
    parameter int NORM_CYC = NORM_CYC_DEF,
    parameter int TO_CYC   = TO_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [NROW_W-1:0] nrow,
    input  logic              sum_out_vld0,
    input  logic              sum_out_vld1,
    input  logic              empty0,
    input  logic              empty1,
    input  logic              full0,
    input  logic              full1,
    output logic              rd_0to1,
    output logic              rd_1to0,
    output logic              sum_req,
    output logic              sum_ld,
    output logic              norm_en,
    output logic [NROW_W-1:0] row_idx,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output logic              err_to
);

    localparam int NCW = (NORM_CYC > 1) ? $clog2(NORM_CYC) : 1;

    state_e            state_q;
    logic [NROW_W-1:0] nrow_q;
    logic [NROW_W-1:0] row_idx_q;
    logic [NCW-1:0]    ncnt_q;
    logic              rd_q;
    logic              sum_req_q;
    logic              sum_ld_q;
    logic              norm_q;
    logic              busy_q;
    logic              done_q;
    logic              both_rdy;
    logic              clr;
    logic              to_hit;

    assign both_rdy = ~empty0 & ~empty1;
    assign clr      = (state_q == IDLE) & start & ~abort;

    assign rd_0to1 = rd_q;
    assign rd_1to0 = rd_q;
    assign sum_req = sum_req_q;
    assign sum_ld  = sum_ld_q;
    assign norm_en = norm_q;
    assign row_idx = row_idx_q;
    assign busy    = busy_q;
    assign done    = done_q;

    xchg_err_mon #(
        .TO_CYC(TO_CYC)
    ) u_err_mon (
        .clk           (clk),
        .reset         (reset),
        .clr_i         (clr),
        .wait_entry_i  (state_q == REQ),
        .in_wait_i     (state_q == WAIT),
        .both_rdy_i    (both_rdy),
        .sum_out_vld0_i(sum_out_vld0),
        .full0_i       (full0),
        .sum_out_vld1_i(sum_out_vld1),
        .full1_i       (full1),
        .err_ovf_o     (err_ovf),
        .err_to_o      (err_to),
        .to_hit_o      (to_hit)
    );

    // Exchange FSM; every output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            nrow_q    <= '0;
            row_idx_q <= '0;
            ncnt_q    <= '0;
            rd_q      <= 1'b0;
            sum_req_q <= 1'b0;
            sum_ld_q  <= 1'b0;
            norm_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (abort) begin
            state_q   <= IDLE;
            ncnt_q    <= '0;
            rd_q      <= 1'b0;
            sum_req_q <= 1'b0;
            sum_ld_q  <= 1'b0;
            norm_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rd_q      <= 1'b0;
            sum_req_q <= 1'b0;
            sum_ld_q  <= 1'b0;
            done_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        nrow_q    <= nrow;
                        row_idx_q <= '0;
                        busy_q    <= 1'b1;
                        if (nrow == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= REQ;
                            sum_req_q <= 1'b1;
                        end
                    end
                end
                REQ: state_q <= WAIT;
                WAIT: begin
                    if (to_hit) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (both_rdy) begin
                        state_q <= POP;
                        rd_q    <= 1'b1;
                    end
                end
                POP: begin
                    state_q  <= LD;
                    sum_ld_q <= 1'b1;
                end
                LD: begin
                    state_q <= NORM;
                    norm_q  <= 1'b1;
                    ncnt_q  <= '0;
                end
                NORM: begin
                    if (ncnt_q == NCW'(NORM_CYC - 1)) begin
                        norm_q <= 1'b0;
                        if (row_idx_q == nrow_q - 1'b1) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            row_idx_q <= row_idx_q + 1'b1;
                            state_q   <= REQ;
                            sum_req_q <= 1'b1;
                        end
                    end else begin
                        ncnt_q <= ncnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_xchg_sched.sv
// Directed self-checking bench for psum_xchg_sched.
// Covers row sequencing, empty runs, paired pops, overflow, abort, timeout.
module tb_psum_xchg_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [4:0] nrow;
    logic       sum_out_vld0;
    logic       sum_out_vld1;
    logic       empty0;
    logic       empty1;
    logic       full0;
    logic       full1;
    logic       rd_0to1;
    logic       rd_1to0;
    logic       sum_req;
    logic       sum_ld;
    logic       norm_en;
    logic [4:0] row_idx;
    logic       busy;
    logic       done;
    logic       err_ovf;
    logic       err_to;

    int checks = 0;
    int errors = 0;

    int n_req, n_rd, n_ld, n_norm, n_done, n_bad;
    int rd_rel, req_c0, first_req, ovf_first, ovf_done, busy_after;
    int ab_busy, ab_row, ab_pulse;
    int rows[$];

    always #5 clk = ~clk;

    psum_xchg_sched #(
        .NROW_W  (5),
        .NORM_CYC(2),
`ifdef XCHG_TIMEOUT_EN
        .TO_CYC  (10)
`else
        .TO_CYC  (255)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .nrow        (nrow),
        .sum_out_vld0(sum_out_vld0),
        .sum_out_vld1(sum_out_vld1),
        .empty0      (empty0),
        .empty1      (empty1),
        .full0       (full0),
        .full1       (full1),
        .rd_0to1     (rd_0to1),
        .rd_1to0     (rd_1to0),
        .sum_req     (sum_req),
        .sum_ld      (sum_ld),
        .norm_en     (norm_en),
        .row_idx     (row_idx),
        .busy        (busy),
        .done        (done),
        .err_ovf     (err_ovf),
        .err_to      (err_to)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    // One run: FIFOs fill lat0/lat1 cycles after each sum_req, a pop empties
    // them. Optional one-cycle overflow injection and abort in NORM of a row.
    task automatic run(input int nr, input int lat0, input int lat1,
                       input int inj, input int abrow, input int maxc);
        int  cd0;
        int  cd1;
        bit  ab;
        cd0 = -1; cd1 = -1; ab = 0;
        n_req = 0; n_rd = 0; n_ld = 0; n_norm = 0; n_done = 0; n_bad = 0;
        rd_rel = -1; req_c0 = -1; first_req = -1; ovf_first = -1;
        ovf_done = -1; busy_after = -1;
        ab_busy = -1; ab_row = -1; ab_pulse = -1;
        rows.delete();
        @(negedge clk);
        nrow  = 5'(nr);
        start = 1'b1;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start     = 1'b0;
                first_req = int'(sum_req);
                ovf_first = int'(err_ovf);
            end
            if (ab) begin
                abort    = 1'b0;
                ab_busy  = int'(busy);
                ab_row   = int'(row_idx);
                ab_pulse = int'(sum_req | rd_0to1 | rd_1to0 | sum_ld
                                | norm_en | done);
                return;
            end
            if (cd0 > 0) cd0--;
            if (cd1 > 0) cd1--;
            if (cd0 == 0) begin empty0 = 1'b0; cd0 = -1; end
            if (cd1 == 0) begin empty1 = 1'b0; cd1 = -1; end
            if (sum_req) begin
                n_req++;
                rows.push_back(int'(row_idx));
                if (req_c0 < 0) req_c0 = c;
                cd0 = lat0;
                cd1 = lat1;
            end
            if (rd_0to1 !== rd_1to0) n_bad++;
            if (rd_0to1) begin
                n_rd++;
                if (empty0 || empty1) n_bad++;
                if (rd_rel < 0) rd_rel = c - req_c0;
                empty0 = 1'b1;
                empty1 = 1'b1;
            end
            if (sum_ld) n_ld++;
            if (norm_en) n_norm++;
            if (done) begin
                n_done++;
                ovf_done = int'(err_ovf);
                @(negedge clk);
                busy_after = int'(busy);
                return;
            end
            full1        = (c == inj);
            sum_out_vld1 = (c == inj);
            if (!ab && abrow >= 0 && norm_en && int'(row_idx) == abrow) begin
                abort = 1'b1;
                ab    = 1;
            end
        end
    endtask

    initial begin
        int nd;
        int nb;
        int nr;
        reset = 1'b1; start = 1'b0; abort = 1'b0; nrow = '0;
        sum_out_vld0 = 1'b0; sum_out_vld1 = 1'b0;
        empty0 = 1'b1; empty1 = 1'b1; full0 = 1'b0; full1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {rd_0to1, rd_1to0, sum_req, sum_ld, norm_en,
                           row_idx, busy, done, err_ovf, err_to}, 0);
        reset = 1'b0;

        // Three rows, FIFOs fill two cycles after each request.
        run(3, 2, 2, -1, -1, 100);
        chk("t1_first_req", first_req, 1);
        chk("t1_n_req", n_req, 3);
        chk("t1_n_rd", n_rd, 3);
        chk("t1_n_ld", n_ld, 3);
        chk("t1_n_norm", n_norm, 6);
        chk("t1_n_done", n_done, 1);
        chk("t1_bad_rd", n_bad, 0);
        chk("t1_rd_rel", rd_rel, 3);
        chk("t1_rows", (rows.size() == 3) ?
            rows[0] * 100 + rows[1] * 10 + rows[2] : -1, 12);
        chk("t1_busy_after", busy_after, 0);

        // Zero rows: straight to DONE and back.
        @(negedge clk);
        nrow = 5'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t2_done_t1", done, 1);
        chk("t2_busy_t1", busy, 1);
        chk("t2_req_t1", sum_req | rd_0to1, 0);
        @(negedge clk);
        chk("t2_done_t2", done, 0);
        chk("t2_busy_t2", busy, 0);

        // Staggered FIFO fill: pop only once both are non-empty.
        run(2, 2, 7, -1, -1, 100);
        chk("t3_rd_rel", rd_rel, 8);
        chk("t3_n_rd", n_rd, 2);
        chk("t3_bad_rd", n_bad, 0);
        chk("t3_n_done", n_done, 1);

        // Overflow mid-run, then cleared by the next start.
        run(3, 2, 2, 4, -1, 100);
        chk("t4_ovf_done", ovf_done, 1);
        chk("t4_n_req", n_req, 3);
        chk("t4_n_done", n_done, 1);
        chk("t4_ovf_hold", err_ovf, 1);
        run(3, 2, 2, -1, -1, 100);
        chk("t4_ovf_clr", ovf_first, 0);
        chk("t4_n_done2", n_done, 1);

        // Abort in NORM of row 1 of 4.
        run(4, 2, 2, -1, 1, 200);
        chk("t5_ab_busy", ab_busy, 0);
        chk("t5_ab_row", ab_row, 1);
        chk("t5_ab_pulse", ab_pulse, 0);
        chk("t5_n_done", n_done, 0);
        chk("t5_n_req", n_req, 2);
        nd = 0;
        repeat (5) begin
            @(negedge clk);
            nd += int'(done);
        end
        chk("t5_no_done", nd, 0);

        // Reset wins over start.
        reset = 1'b1; start = 1'b1; nrow = 5'd3;
        @(negedge clk);
        chk("t5_rst_start", {busy, sum_req}, 0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("t5_rst_idle", busy, 0);

        // FIFOs stay empty in WAIT.
        empty0 = 1'b1; empty1 = 1'b1;
        nrow = 5'd1; start = 1'b1;
        nd = 0; nb = 0; nr = 0;
`ifdef XCHG_TIMEOUT_EN
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            nd += int'(done);
            if (c == 11) begin
                chk("t6_busy_c11", busy, 1);
                chk("t6_to_c11", err_to, 0);
            end
        end
        chk("t6_busy_idle", busy, 0);
        chk("t6_err_to", err_to, 1);
        chk("t6_no_done", nd, 0);
`else
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            start = 1'b0;
            nd += int'(done);
            nb += int'(busy);
            nr += int'(rd_0to1 | rd_1to0);
        end
        chk("t6_busy_300", nb, 300);
        chk("t6_no_rd", nr, 0);
        chk("t6_no_done", nd, 0);
        chk("t6_err_to", err_to, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t6_abort_idle", busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
